wptr_full_handler: RTL and testbench
====================================

Name: wptr_full_handler

Overview:
- Write-side pointer and status logic of the team's asynchronous FIFO.
- It is the counterpart of the read-pointer/empty handler and runs in the write clock domain.
- It advances the binary and Gray write pointers and produces a registered full flag by comparing against the read pointer after it has been synchronised into wclk.
- It also produces a fill level, an almost_full flag and a sticky overflow flag for upstream flow control.

Parameters:
- PTR_WIDTH, 3: address bits. FIFO depth = 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits. Legal range ≥ 2.
- AF_MARGIN, 1: almost_full asserts when free entries ≤ AF_MARGIN. Legal range 0..2**PTR_WIDTH-1.

Ports:
- wclk  input  1  write clock
- wrst_n  input  1  asynchronous active-low reset
- w_en  input  1  write request from the producer
- g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already 2-flop synchronised into wclk
- clr_ovf  input  1  clears the sticky overflow flag
- b_wptr  output  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits address the RAM
- g_wptr  output  PTR_WIDTH+1  Gray write pointer, sent to the read-domain synchroniser
- full  output  1  FIFO full, registered
- almost_full  output  1  free entries ≤ AF_MARGIN, registered
- wr_level  output  PTR_WIDTH+1  occupied entries as seen from the write side, 0..2**PTR_WIDTH, registered
- overflow  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset, asynchronous with wrst_n low, all outputs take these values immediately and independently of wclk:
  - b_wptr=0, g_wptr=0, full=0, almost_full=0 (1 if AF_MARGIN ≥ depth is ever allowed; it is not), wr_level=0, overflow=0.
- Accept: a write is accepted in a cycle iff w_en=1 and full=0.
- Pointer advance:
  - Next binary pointer: b_next = b_wptr + accept, modulo 2**(PTR_WIDTH+1). It wraps naturally from all-ones to 0.
  - Next Gray pointer: g_next = (b_next >> 1) XOR b_next.
  - Both pointers register b_next and g_next on every wclk edge, giving 1-cycle latency from accept to pointer update.
  - g_wptr changes by exactly one bit per accepted write; this is mandatory for CDC safety.
- Full detection:
  - full_next = (g_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
  - full registers full_next each edge, so it asserts on the same edge that the last-slot write lands.
  - full is pessimistic: it deasserts only after a read-pointer change has crossed the synchroniser, with a 1-cycle register delay after g_rptr_sync changes.
- Level:
  - b_rptr_s = Gray-to-binary of g_rptr_sync, combinational: bit PTR_WIDTH = g[PTR_WIDTH]; bit i = b[i+1] XOR g[i].
  - level_next = b_next − b_rptr_s, modulo 2**(PTR_WIDTH+1). wr_level registers level_next.
  - level_next never exceeds 2**PTR_WIDTH under legal synchroniser operation.
- almost_full: registers (level_next ≥ 2**PTR_WIDTH − AF_MARGIN). With AF_MARGIN=0 it equals full.
- overflow:
  - Set when w_en=1 and full=1. The rejected write leaves the pointers unchanged.
  - Cleared by clr_ovf=1.
  - If set and clear occur in the same cycle, set wins.
  - Only reset or clr_ovf clears it.
- Simultaneous events:
  - A write and a read-pointer change in the same cycle are both reflected in that edge's full and wr_level, because both use b_next and the current g_rptr_sync.
  - A write on the cycle full deasserts is accepted, since accept uses the registered full.
- Reset mid-operation: pointers return to 0 asynchronously. The read domain must be reset together with the write domain; this block does not detect mismatched resets.
- No RAM is instantiated here. The RAM write enable is w_en & ~full, and the RAM address is b_wptr[PTR_WIDTH-1:0].

Test Plan (PTR_WIDTH=3, AF_MARGIN=2 unless stated):
- Reset:
  - Stimulus: drive wrst_n low mid-cycle with w_en=1.
  - Required: all outputs 0 immediately, and no pointer movement while reset is held.
- Fill:
  - Stimulus: g_rptr_sync=0, w_en=1 for 8 cycles.
  - Required: after the 6th edge wr_level=6 and almost_full=1.
  - Required: after the 8th edge b_wptr=8, g_wptr=4'b1100, full=1, wr_level=8.
- Overflow:
  - Stimulus: with full=1, hold w_en=1 for 3 more cycles.
  - Required: b_wptr stays 8 and overflow=1.
  - Stimulus: assert clr_ovf=1 together with w_en=1 while still full.
  - Required: overflow stays 1 (set wins).
  - Stimulus: assert clr_ovf with w_en=0.
  - Required: overflow=0.
- Drain visibility:
  - Stimulus: from full, set g_rptr_sync=4'b0011 (binary 2) with w_en=0.
  - Required: next edge gives full=0, wr_level=6, almost_full=1.
  - Stimulus: then set g_rptr_sync=4'b0110 (binary 4).
  - Required: wr_level=4 and almost_full=0.
- Wrap-around:
  - Stimulus: 20 writes, with the bench advancing g_rptr_sync to track 2 entries behind.
  - Required: b_wptr goes 15→0 (g_wptr 4'b1000→4'b0000), full never asserts, and every g_wptr step flips exactly one bit.
- Simultaneous:
  - Stimulus: at wr_level=7, w_en=1 on the same cycle g_rptr_sync advances by 1.
  - Required: next edge gives wr_level=7 and full=0.

Source files
------------

// File: rtl/wptr_full_handler.sv
// Write-side pointer, full, level and overflow logic of the asynchronous FIFO.
// Runs entirely in the write clock domain. The Gray read pointer arrives here
// already synchronised into wclk. Full, almost_full and wr_level therefore
// report conservatively: read-side progress only becomes visible once it has
// crossed the synchroniser.
module wptr_full_handler #(
  parameter int unsigned PTR_WIDTH = 3,
  parameter int unsigned AF_MARGIN = 1
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic                 clr_ovf,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic                 overflow
);

  // Pointer width carries one extra wrap bit above the address bits.
  localparam int unsigned PW       = PTR_WIDTH + 1;
  localparam int unsigned DEPTH    = 1 << PTR_WIDTH;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic          accept;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] g_full_cmp;
  logic [PW-1:0] b_rptr_s;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          af_next;
  logic          ovf_next;

  // Writes are gated by the registered full flag, so a write on the cycle
  // full drops is accepted.
  assign accept = w_en & ~full;

  // Next binary pointer wraps naturally; Gray form changes one bit per step.
  assign b_next = b_wptr + PW'(accept);
  assign g_next = (b_next >> 1) ^ b_next;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that is the read pointer with its top two bits inverted.
  assign g_full_cmp = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
  assign full_next  = (g_next == g_full_cmp);

  // Gray-to-binary conversion of the synchronised read pointer.
  always_comb begin
    b_rptr_s         = '0;
    b_rptr_s[PW-1]   = g_rptr_sync[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b_rptr_s[i] = b_rptr_s[i+1] ^ g_rptr_sync[i];
    end
  end

  // Occupancy seen from the write side; modulo arithmetic handles the wrap.
  assign level_next = b_next - b_rptr_s;
  assign af_next    = (level_next >= PW'(AF_LEVEL));

  // Sticky overflow: a rejected write sets it and wins over a same-cycle clear.
  assign ovf_next = (w_en & full) | (overflow & ~clr_ovf);

  // Register pointers and all status outputs.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      full        <= full_next;
      almost_full <= af_next;
      wr_level    <= level_next;
      overflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_wptr_full_handler.sv
// Self-checking bench for wptr_full_handler (PTR_WIDTH=3, AF_MARGIN=2).
// Reference model tracks total writes and total reads as plain integers.
module tb_wptr_full_handler;

  localparam int unsigned PTR_WIDTH = 3;
  localparam int unsigned AF_MARGIN = 2;
  localparam int DEPTH = 8;

  logic       wclk;
  logic       wrst_n;
  logic       w_en;
  logic [3:0] g_rptr_sync;
  logic       clr_ovf;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  wptr_full_handler #(.PTR_WIDTH(PTR_WIDTH), .AF_MARGIN(AF_MARGIN)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .g_rptr_sync(g_rptr_sync),
    .clr_ovf(clr_ovf), .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int total_checks;
  int pass_checks;

  // Reference model state: unbounded write/read counts.
  int   wr_cnt;
  int   rd_cnt;
  logic m_full;
  logic m_ovf;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_level();
    return wr_cnt - rd_cnt;
  endfunction

  task automatic model_reset();
    wr_cnt = 0;
    rd_cnt = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of stimulus at negedge, advance the model, then sample
  // one time unit after the active edge.
  task automatic step(input logic we, input logic clr, input int rd);
    @(negedge wclk);
    w_en        = we;
    clr_ovf     = clr;
    rd_cnt      = rd;
    g_rptr_sync = to_gray(rd);
    m_ovf  = (we && m_full) || (m_ovf && !clr);
    if (we && !m_full) wr_cnt++;
    m_full = (exp_level() == DEPTH);
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    total_checks++;
    if ({b_wptr, g_wptr, full, almost_full, wr_level, overflow} !== '0)
      $display("FAIL reset_initial: got b=%0d g=%b f=%b af=%b lvl=%0d ovf=%b, want all 0",
               b_wptr, g_wptr, full, almost_full, wr_level, overflow);
    else pass_checks++;
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    total_checks++;
    if (b_wptr !== 4'd3) $display("FAIL pre_reset_ptr: got %0d want 3", b_wptr);
    else pass_checks++;
    // Assert reset mid-cycle, away from both edges, while writing.
    @(posedge wclk);
    #2;
    w_en   = 1'b1;
    wrst_n = 1'b0;
    #1;
    total_checks++;
    if ({b_wptr, g_wptr, full, almost_full, wr_level, overflow} !== '0)
      $display("FAIL reset_async: got b=%0d g=%b f=%b af=%b lvl=%0d ovf=%b, want all 0",
               b_wptr, g_wptr, full, almost_full, wr_level, overflow);
    else pass_checks++;
    for (int i = 0; i < 3; i++) begin
      @(posedge wclk);
      #1;
      total_checks++;
      if (b_wptr !== 4'd0 || g_wptr !== 4'd0)
        $display("FAIL reset_hold: got b=%0d g=%b want 0", b_wptr, g_wptr);
      else pass_checks++;
    end
    @(negedge wclk);
    w_en        = 1'b0;
    g_rptr_sync = 4'd0;
    wrst_n      = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 0);
      if (i == 6) begin
        total_checks++;
        if (wr_level !== 4'd6 || almost_full !== 1'b1 || full !== 1'b0)
          $display("FAIL fill_6: got lvl=%0d af=%b f=%b want 6 1 0", wr_level, almost_full, full);
        else pass_checks++;
      end
    end
    total_checks++;
    if (b_wptr !== 4'd8 || g_wptr !== 4'b1100 || full !== 1'b1 || wr_level !== 4'd8)
      $display("FAIL fill_8: got b=%0d g=%b f=%b lvl=%0d want 8 1100 1 8",
               b_wptr, g_wptr, full, wr_level);
    else pass_checks++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0);
      total_checks++;
      if (b_wptr !== 4'd8 || overflow !== 1'b1 || full !== 1'b1)
        $display("FAIL ovf_set: got b=%0d ovf=%b f=%b want 8 1 1", b_wptr, overflow, full);
      else pass_checks++;
    end
    step(1'b1, 1'b1, 0);
    total_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", overflow);
    else pass_checks++;
    step(1'b0, 1'b1, 0);
    total_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else pass_checks++;
    step(1'b0, 1'b0, 0);
    total_checks++;
    if (overflow !== 1'b0 || b_wptr !== 4'd8) $display("FAIL ovf_stays_clear: got ovf=%b b=%0d want 0 8", overflow, b_wptr);
    else pass_checks++;
  endtask

  task automatic test_drain();
    step(1'b0, 1'b0, 2);
    total_checks++;
    if (g_rptr_sync !== 4'b0011 || full !== 1'b0 || wr_level !== 4'd6 || almost_full !== 1'b1)
      $display("FAIL drain_2: got f=%b lvl=%0d af=%b want 0 6 1", full, wr_level, almost_full);
    else pass_checks++;
    step(1'b0, 1'b0, 4);
    total_checks++;
    if (g_rptr_sync !== 4'b0110 || wr_level !== 4'd4 || almost_full !== 1'b0)
      $display("FAIL drain_4: got lvl=%0d af=%b want 4 0", wr_level, almost_full);
    else pass_checks++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4);
    total_checks++;
    if (wr_level !== 4'd7 || full !== 1'b0)
      $display("FAIL simul_setup: got lvl=%0d f=%b want 7 0", wr_level, full);
    else pass_checks++;
    step(1'b1, 1'b0, 5);
    total_checks++;
    if (wr_level !== 4'd7 || full !== 1'b0 || b_wptr !== 4'd12)
      $display("FAIL simul: got lvl=%0d f=%b b=%0d want 7 0 12", wr_level, full, b_wptr);
    else pass_checks++;
  endtask

  task automatic test_wrap();
    logic [3:0] prev_b;
    logic [3:0] prev_g;
    bit seen_wrap;
    int bad_steps;
    seen_wrap = 0;
    bad_steps = 0;
    prev_b = b_wptr;
    prev_g = g_wptr;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, wr_cnt - 2);
      if (full !== 1'b0 || $countones(g_wptr ^ prev_g) != 1 || b_wptr !== 4'(wr_cnt)) bad_steps++;
      if (prev_b == 4'd15 && b_wptr == 4'd0 && prev_g == 4'b1000 && g_wptr == 4'b0000) seen_wrap = 1;
      prev_b = b_wptr;
      prev_g = g_wptr;
    end
    total_checks++;
    if (bad_steps != 0) $display("FAIL wrap_steps: got %0d bad steps want 0", bad_steps);
    else pass_checks++;
    total_checks++;
    if (!seen_wrap) $display("FAIL wrap_15_to_0: got no 15->0 (1000->0000) transition want one");
    else pass_checks++;
  endtask

  task automatic test_random();
    int errs;
    logic [3:0] prev_g;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      int room;
      int adv;
      logic we;
      logic clr;
      prev_g = g_wptr;
      room = wr_cnt - rd_cnt;
      adv  = int'($urandom_range(0, 2));
      if (adv > room) adv = room;
      we  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step(we, clr, rd_cnt + adv);
      if (b_wptr !== 4'(wr_cnt) || g_wptr !== to_gray(wr_cnt) || full !== m_full ||
          almost_full !== (exp_level() >= DEPTH - int'(AF_MARGIN)) ||
          wr_level !== 4'(exp_level()) || overflow !== m_ovf ||
          (g_wptr !== prev_g && $countones(g_wptr ^ prev_g) != 1)) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_cycle %0d: got b=%0d f=%b af=%b lvl=%0d ovf=%b want b=%0d f=%b lvl=%0d ovf=%b",
                   i, b_wptr, full, almost_full, wr_level, overflow,
                   wr_cnt % 16, m_full, exp_level(), m_ovf);
      end
    end
    total_checks++;
    if (errs != 0) $display("FAIL random: got %0d mismatching cycles want 0", errs);
    else pass_checks++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total_checks = 0;
    pass_checks  = 0;
    wrst_n       = 1'b0;
    w_en         = 1'b0;
    clr_ovf      = 1'b0;
    g_rptr_sync  = 4'd0;
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
